// File: rtl/unidade_controle_exp5.sv
// unidade_controle_exp5: Moore FSM that sequences the memory-game datapath, with a per-move inactivity timeout.
module unidade_controle_exp5 #(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int TW = 13
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       enderecoIgualLimite,
    input  logic       fimL,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraL,
    output logic       contaL,
    output logic       zeraR,
    output logic       registraR,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic       pronto,
    output logic [3:0] db_estado
);
    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        ESPERA_JOGADA  = 4'h2,
        REGISTRA       = 4'h3,
        COMPARACAO     = 4'h4,
        PROXIMA_JOGADA = 4'h5,
        PROXIMA_RODADA = 4'h6,
        FIM_ACERTOU    = 4'hA,
        FIM_TIMEOUT    = 4'hD,
        FIM_ERROU      = 4'hE
    } state_t;

    state_t        state, nxt;
    logic [TW-1:0] timer;
    logic          expired;

    assign expired   = timer == TW'(TIMEOUT_CYCLES - 1);
    assign db_estado = state;

    always_comb begin
        nxt = INICIAL;
        case (state)
            INICIAL:        nxt = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:     nxt = ESPERA_JOGADA;
            ESPERA_JOGADA:  nxt = jogada ? REGISTRA : expired ? FIM_TIMEOUT : ESPERA_JOGADA;
            REGISTRA:       nxt = COMPARACAO;
            COMPARACAO:     nxt = !igual ? FIM_ERROU : !enderecoIgualLimite ? PROXIMA_JOGADA :
                                  fimL ? FIM_ACERTOU : PROXIMA_RODADA;
            PROXIMA_JOGADA: nxt = ESPERA_JOGADA;
            PROXIMA_RODADA: nxt = ESPERA_JOGADA;
            FIM_ACERTOU:    nxt = iniciar ? PREPARACAO : FIM_ACERTOU;
            FIM_ERROU:      nxt = iniciar ? PREPARACAO : FIM_ERROU;
            FIM_TIMEOUT:    nxt = iniciar ? PREPARACAO : FIM_TIMEOUT;
            default:        nxt = INICIAL;
        endcase
    end

    // Outputs are registered from the decode of the next state, so they track the state register exactly.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= INICIAL;
            timer     <= '0;
            zeraE     <= 1'b0;
            contaE    <= 1'b0;
            zeraL     <= 1'b0;
            contaL    <= 1'b0;
            zeraR     <= 1'b0;
            registraR <= 1'b0;
            acertou   <= 1'b0;
            errou     <= 1'b0;
            timeout   <= 1'b0;
            pronto    <= 1'b0;
        end else begin
            state     <= nxt;
            timer     <= (state == ESPERA_JOGADA && nxt == ESPERA_JOGADA) ? timer + 1'b1 : '0;
            zeraE     <= nxt == PREPARACAO || nxt == PROXIMA_RODADA;
            contaE    <= nxt == PROXIMA_JOGADA;
            zeraL     <= nxt == PREPARACAO;
            contaL    <= nxt == PROXIMA_RODADA;
            zeraR     <= nxt == PREPARACAO;
            registraR <= nxt == REGISTRA;
            acertou   <= nxt == FIM_ACERTOU;
            errou     <= nxt == FIM_ERROU || nxt == FIM_TIMEOUT;
            timeout   <= nxt == FIM_TIMEOUT;
            pronto    <= nxt == FIM_ACERTOU || nxt == FIM_ERROU || nxt == FIM_TIMEOUT;
        end
    end
endmodule

// File: tb/tb_unidade_controle_exp5.sv
// tb_unidade_controle_exp5: directed vectors for the memory-game control FSM with TIMEOUT_CYCLES=8.
module tb_unidade_controle_exp5;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0, jogada = 1'b0, igual = 1'b0, enderecoIgualLimite = 1'b0, fimL = 1'b0;
    logic       zeraE, contaE, zeraL, contaL, zeraR, registraR, acertou, errou, timeout, pronto;
    logic [3:0] db_estado;
    logic [9:0] outs;
    int         n_cmp = 0, n_bad = 0;

    // Bit order: zeraE contaE zeraL contaL zeraR registraR acertou errou timeout pronto
    localparam logic [9:0] O_NONE = 10'b0000000000;
    localparam logic [9:0] O_PREP = 10'b1010100000;
    localparam logic [9:0] O_REG  = 10'b0000010000;
    localparam logic [9:0] O_PJ   = 10'b0100000000;
    localparam logic [9:0] O_PR   = 10'b1001000000;
    localparam logic [9:0] O_WIN  = 10'b0000001001;
    localparam logic [9:0] O_ERR  = 10'b0000000101;
    localparam logic [9:0] O_TOUT = 10'b0000000111;

    assign outs = {zeraE, contaE, zeraL, contaL, zeraR, registraR, acertou, errou, timeout, pronto};

    unidade_controle_exp5 #(.TIMEOUT_CYCLES(8), .TW(4)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada), .igual(igual),
        .enderecoIgualLimite(enderecoIgualLimite), .fimL(fimL),
        .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL), .zeraR(zeraR),
        .registraR(registraR), .acertou(acertou), .errou(errou), .timeout(timeout),
        .pronto(pronto), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic expect_st(input string tag, input logic [3:0] st, input logic [9:0] o);
        check({tag, ".estado"}, {6'd0, db_estado}, {6'd0, st});
        check({tag, ".saidas"}, outs, o);
    endtask

    initial begin
        tick(); tick();
        expect_st("reset", 4'h0, O_NONE);
        reset = 1'b1;
        tick();
        expect_st("idle", 4'h0, O_NONE);
        iniciar = 1'b1; tick(); iniciar = 1'b0;
        expect_st("prep", 4'h1, O_PREP);
        tick();
        expect_st("espera0", 4'h2, O_NONE);

        // correct move closing a round
        jogada = 1'b1; igual = 1'b1; enderecoIgualLimite = 1'b1; fimL = 1'b0;
        tick(); jogada = 1'b0;
        expect_st("rod.reg", 4'h3, O_REG);
        tick(); expect_st("rod.cmp", 4'h4, O_NONE);
        tick(); expect_st("rod.prox", 4'h6, O_PR);
        tick(); expect_st("rod.espera", 4'h2, O_NONE);

        // final move wins
        fimL = 1'b1; jogada = 1'b1;
        tick(); jogada = 1'b0;
        expect_st("win.reg", 4'h3, O_REG);
        tick(); expect_st("win.cmp", 4'h4, O_NONE);
        tick(); expect_st("win", 4'hA, O_WIN);
        tick(); tick(); expect_st("win.hold", 4'hA, O_WIN);
        iniciar = 1'b1; tick(); iniciar = 1'b0;
        expect_st("win.restart", 4'h1, O_PREP);
        tick(); expect_st("espera1", 4'h2, O_NONE);

        // move accepted in the last allowed cycle
        fimL = 1'b0; enderecoIgualLimite = 1'b0;
        for (int i = 1; i <= 7; i++) tick();
        expect_st("bound.espera8", 4'h2, O_NONE);
        jogada = 1'b1; tick(); jogada = 1'b0;
        expect_st("bound.reg", 4'h3, O_REG);
        tick(); expect_st("bound.cmp", 4'h4, O_NONE);
        tick(); expect_st("bound.pj", 4'h5, O_PJ);
        tick(); expect_st("bound.espera", 4'h2, O_NONE);

        // timer restarted: full 8 cycles then timeout
        for (int i = 1; i <= 7; i++) begin
            tick();
            check("tout.wait", {6'd0, db_estado}, 10'h2);
        end
        tick(); expect_st("tout", 4'hD, O_TOUT);
        tick(); expect_st("tout.hold", 4'hD, O_TOUT);

        // restart, then iniciar mid-game is ignored, then async reset aborts
        iniciar = 1'b1; tick(); iniciar = 1'b0;
        expect_st("tout.restart", 4'h1, O_PREP);
        tick(); tick(); tick();
        iniciar = 1'b1; tick(); iniciar = 1'b0;
        expect_st("ign.iniciar", 4'h2, O_NONE);
        #2 reset = 1'b0;
        #1 expect_st("async.reset", 4'h0, O_NONE);
        tick(); expect_st("reset.hold", 4'h0, O_NONE);
        reset = 1'b1;
        iniciar = 1'b1; tick(); iniciar = 1'b0;
        expect_st("prep2", 4'h1, O_PREP);
        tick(); expect_st("espera2", 4'h2, O_NONE);

        // wrong move
        igual = 1'b0; jogada = 1'b1;
        tick(); jogada = 1'b0;
        expect_st("err.reg", 4'h3, O_REG);
        tick(); expect_st("err.cmp", 4'h4, O_NONE);
        tick(); expect_st("err", 4'hE, O_ERR);
        jogada = 1'b1; tick(); jogada = 1'b0;
        expect_st("err.jogada", 4'hE, O_ERR);
        tick(); expect_st("err.hold", 4'hE, O_ERR);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
